// File: rtl/mapped_spi_flash_pkg.sv
// spi_flash_pkg: shared constants, FSM state type and byte-swap helper for the
// memory-mapped SPI flash reader.
// Ports: none (package).
package spi_flash_pkg;
  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;

  typedef enum logic [2:0] {IDLE, SEND, DUMMY, RECV, DONE} state_t;

  localparam int CMD_ADDR_BITS = 32;
  localparam int DUMMY_BITS    = 8;
  localparam int DATA_BITS     = 32;

  // Flash returns bytes in ascending address order; the first byte received
  // lands in the least significant byte of the CPU word.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
endpackage

// File: rtl/mapped_spi_flash_sck_gen.sv
// spi_sck_gen: SCK divider. While en=1, sck toggles every SCK_HALF clk cycles
// starting from low; rise/fall pulse high in the cycle whose closing clk edge
// makes sck go high/low. en=0 holds sck low and restarts the divider.
// Ports: clk, resetn (sync, active low), en, sck, rise, fall.
module spi_sck_gen #(
  parameter int SCK_HALF = 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);
  localparam int CW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick = en && (cnt == CW'(SCK_HALF - 1));
  assign rise = tick && !sck;
  assign fall = tick && sck;

  always_ff @(posedge clk) begin
    if (!resetn || !en) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (tick) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/mapped_spi_flash.sv
// mapped_spi_flash: read-only memory-mapped window onto a SPI NOR flash.
// One rstrb pulse fetches one little-endian 32-bit word via READ (0x03), mode 0.
// Optional macro FAST_READ_EN: use FAST_READ (0x0B) with 8 dummy clocks.
// Ports: clk, resetn (sync, active low), word_address, rstrb -> rdata, rbusy;
//        flash side CLK, CS_N, MOSI (out), MISO (in).
module mapped_spi_flash
  import spi_flash_pkg::*;
#(
  parameter int SCK_HALF = 1,
  parameter int ADDR_W   = 20
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] word_address,
  input  logic              rstrb,
  output logic [31:0]       rdata,
  output logic              rbusy,
  output logic              CLK,
  output logic              CS_N,
  output logic              MOSI,
  input  logic              MISO
);
`ifdef FAST_READ_EN
  localparam logic [7:0] CMD        = CMD_FAST_READ;
  localparam state_t     AFTER_SEND = DUMMY;
`else
  localparam logic [7:0] CMD        = CMD_READ;
  localparam state_t     AFTER_SEND = RECV;
`endif

  state_t      state;
  logic [31:0] shift, rx;
  logic [5:0]  bitcnt;
  logic        setup, cs_n_q, rbusy_q;
  logic        sck_en, sck, sck_rise, sck_fall;
  logic [23:0] faddr;

  assign faddr = 24'({word_address, 2'b00});

  // The first selected cycle is a setup cycle (MOSI settles, SCK stays low);
  // SCK stops once the last falling edge has moved the FSM into DONE.
  assign sck_en = !cs_n_q && !setup && (state != DONE);

  spi_sck_gen #(.SCK_HALF(SCK_HALF)) u_sck (
    .clk    (clk),
    .resetn (resetn),
    .en     (sck_en),
    .sck    (sck),
    .rise   (sck_rise),
    .fall   (sck_fall)
  );

  assign CLK   = sck;
  assign CS_N  = cs_n_q;
  assign rbusy = rbusy_q;

  always_comb begin
    MOSI = 1'b0;
    case (state)
      SEND:        MOSI = shift[31];
      DUMMY, RECV: MOSI = 1'b1;
      default:     MOSI = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      shift   <= '0;
      rx      <= '0;
      bitcnt  <= '0;
      setup   <= 1'b0;
      cs_n_q  <= 1'b1;
      rbusy_q <= 1'b0;
      rdata   <= '0;
    end else begin
      setup <= 1'b0;
      case (state)
        IDLE: if (rstrb) begin
          shift   <= {CMD, faddr};
          cs_n_q  <= 1'b0;
          rbusy_q <= 1'b1;
          setup   <= 1'b1;
          bitcnt  <= '0;
          state   <= SEND;
        end
        SEND: if (sck_fall) begin
          shift <= {shift[30:0], 1'b0};
          if (bitcnt == 6'(CMD_ADDR_BITS - 1)) begin
            bitcnt <= '0;
            state  <= AFTER_SEND;
          end else bitcnt <= bitcnt + 1'b1;
        end
        DUMMY: if (sck_fall) begin
          if (bitcnt == 6'(DUMMY_BITS - 1)) begin
            bitcnt <= '0;
            state  <= RECV;
          end else bitcnt <= bitcnt + 1'b1;
        end
        RECV: begin
          if (sck_rise) rx <= {rx[30:0], MISO};
          if (sck_fall) begin
            if (bitcnt == 6'(DATA_BITS - 1)) begin
              bitcnt <= '0;
              state  <= DONE;
            end else bitcnt <= bitcnt + 1'b1;
          end
        end
        DONE: begin
          rdata   <= bswap32(rx);
          cs_n_q  <= 1'b1;
          rbusy_q <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mapped_spi_flash.sv
// tb_mapped_spi_flash: directed self-checking bench. Two DUTs (SCK_HALF=1 and
// SCK_HALF=3) each drive a behavioural SPI flash model. Honours FAST_READ_EN.
module tb_mapped_spi_flash;
`ifdef FAST_READ_EN
  localparam logic [7:0] CMDB = 8'h0B;
  localparam int DSTART = 40;
`else
  localparam logic [7:0] CMDB = 8'h03;
  localparam int DSTART = 32;
`endif
  localparam int NB    = DSTART + 32;     // SCK periods per transaction
  localparam int EXPB0 = 2 + 2 * NB;      // busy cycles, SCK_HALF=1
  localparam int EXPB1 = 2 + 6 * NB;      // busy cycles, SCK_HALF=3

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [19:0] waddr = '0;
  logic [1:0]  rstrb_w = '0;
  logic [1:0]  rbusy_w, sck_w, csn_w, mosi_w, miso_w;
  logic [31:0] rdata_w [2];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  mapped_spi_flash #(.SCK_HALF(1), .ADDR_W(20)) dut0 (
    .clk(clk), .resetn(resetn), .word_address(waddr), .rstrb(rstrb_w[0]),
    .rdata(rdata_w[0]), .rbusy(rbusy_w[0]), .CLK(sck_w[0]), .CS_N(csn_w[0]),
    .MOSI(mosi_w[0]), .MISO(miso_w[0]));

  mapped_spi_flash #(.SCK_HALF(3), .ADDR_W(20)) dut1 (
    .clk(clk), .resetn(resetn), .word_address(waddr), .rstrb(rstrb_w[1]),
    .rdata(rdata_w[1]), .rbusy(rbusy_w[1]), .CLK(sck_w[1]), .CS_N(csn_w[1]),
    .MOSI(mosi_w[1]), .MISO(miso_w[1]));

  function automatic logic [7:0] fbyte(input logic [23:0] a);
    case (a)
      24'h080000: return 8'h13;
      24'h080001: return 8'h05;
      24'h080002: return 8'h00;
      24'h080003: return 8'h00;
      24'h080004: return 8'h67;
      24'h080005: return 8'h00;
      24'h080006: return 8'h05;
      24'h080007: return 8'h00;
      default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] fword(input logic [23:0] a);
    return {fbyte(a + 24'd3), fbyte(a + 24'd2), fbyte(a + 24'd1), fbyte(a)};
  endfunction

  // Flash model: mode 0, samples MOSI on SCK rise, drives MISO after SCK fall.
  for (genvar g = 0; g < 2; g++) begin : fl
    int cnt = 0, last_rises = 0, bad_mosi = 0, total_rises = 0;
    int cs_falls = 0, hi_cnt = 0, last_gap = 0;
    logic [31:0] cmdw = '0;
    logic [23:0] addr = '0;
    time last_t = 0, period = 0;
    logic m = 1'b0;
    assign miso_w[g] = m;

    always @(posedge sck_w[g] or posedge csn_w[g]) begin
      if (csn_w[g] === 1'b1) begin
        if (sck_w[g] === 1'b1) total_rises++;
        last_rises = cnt;
        cnt = 0;
      end else if (csn_w[g] === 1'b0) begin
        if (cnt < 32) cmdw = {cmdw[30:0], mosi_w[g]};
        else if (mosi_w[g] !== 1'b1) bad_mosi++;
        cnt++;
        if (cnt == 32) addr = cmdw[23:0];
        total_rises++;
        period = $time - last_t;
        last_t = $time;
      end
    end

    always @(negedge sck_w[g]) begin
      if (csn_w[g] === 1'b0 && cnt >= DSTART) begin
        automatic int idx = cnt - DSTART;
        automatic logic [7:0] b = fbyte(addr + 24'(idx / 8));
        m = b[7 - idx % 8];
      end
    end

    always @(posedge clk) begin
      if (csn_w[g] === 1'b1) hi_cnt++;
      else if (csn_w[g] === 1'b0) begin
        if (hi_cnt > 0) begin
          cs_falls++;
          last_gap = hi_cnt;
        end
        hi_cnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one read on instance i; returns data and number of busy cycles.
  task automatic do_read(input int i, input logic [19:0] wa, input bit spam,
                         input int poke_at, output logic [31:0] d, output int n);
    waddr = wa;
    rstrb_w[i] = 1'b1;
    @(posedge clk); #1;
    rstrb_w[i] = 1'b0;
    n = 0;
    while (rbusy_w[i] && n < 3000) begin
      rstrb_w[i] = (spam && (n % 9 == 4)) || (n == poke_at);
      n++;
      @(posedge clk); #1;
    end
    rstrb_w[i] = 1'b0;
    d = rdata_w[i];
  endtask

  initial begin
    logic [31:0] d;
    int n, falls0, rises0;

    // reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_csn", 32'(csn_w), 32'h3);
    chk("rst_clk", 32'(sck_w), 32'h0);
    chk("rst_busy", 32'(rbusy_w), 32'h0);
    chk("rst_rdata0", rdata_w[0], 32'h0);
    chk("rst_rdata1", rdata_w[1], 32'h0);
    resetn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_no_sck0", 32'(fl[0].total_rises), 32'd0);
    chk("idle_no_sck1", 32'(fl[1].total_rises), 32'd0);

    // basic read
    do_read(0, 20'h20000, 1'b0, -1, d, n);
    chk("rd0_data", d, 32'h00000513);
    chk("rd0_busy", 32'(n), 32'(EXPB0));
    chk("rd0_cmd", fl[0].cmdw, {CMDB, 24'h080000});
    chk("rd0_sck_periods", 32'(fl[0].last_rises), 32'(NB));
    chk("rd0_mosi_high", 32'(fl[0].bad_mosi), 32'd0);

    do_read(0, 20'h20001, 1'b0, -1, d, n);
    chk("rd1_data", d, 32'h00050067);
    chk("rd1_cmd", fl[0].cmdw, {CMDB, 24'h080004});

    // max address
    do_read(0, 20'hFFFFF, 1'b0, -1, d, n);
    chk("max_cmd", fl[0].cmdw, {CMDB, 24'h3FFFFC});
    chk("max_data", d, fword(24'h3FFFFC));
    chk("max_busy", 32'(n), 32'(EXPB0));

    // rstrb while busy and in the DONE cycle are ignored
    falls0 = fl[0].cs_falls;
    do_read(0, 20'h00123, 1'b1, EXPB0 - 1, d, n);
    chk("spam_busy", 32'(n), 32'(EXPB0));
    chk("spam_data", d, fword(24'h00048C));
    @(posedge clk); #1;
    chk("done_poke_ignored", 32'(rbusy_w[0]), 32'd0);
    chk("spam_one_txn", 32'(fl[0].cs_falls - falls0), 32'd1);

    // back-to-back: second strobe on the first idle cycle
    do_read(0, 20'h20001, 1'b0, -1, d, n);
    falls0 = fl[0].cs_falls;
    do_read(0, 20'h20000, 1'b0, -1, d, n);
    chk("b2b_started", 32'(fl[0].cs_falls - falls0), 32'd1);
    chk("b2b_gap", 32'(fl[0].last_gap >= 1), 32'd1);
    chk("b2b_data", d, 32'h00000513);
    chk("b2b_busy", 32'(n), 32'(EXPB0));

    // reset during RECV bit 10
    waddr = 20'h20001;
    rstrb_w[0] = 1'b1;
    @(posedge clk); #1;
    rstrb_w[0] = 1'b0;
    n = 0;
    while (fl[0].cnt != DSTART + 10 && n < 1000) begin
      n++;
      @(posedge clk); #1;
    end
    chk("mid_reached", 32'(n < 1000), 32'd1);
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("mid_csn", 32'(csn_w[0]), 32'd1);
    chk("mid_busy", 32'(rbusy_w[0]), 32'd0);
    chk("mid_clk", 32'(sck_w[0]), 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    do_read(0, 20'h20000, 1'b0, -1, d, n);
    chk("post_rst_data", d, 32'h00000513);

    // divided SCK
    rises0 = fl[1].total_rises;
    do_read(1, 20'h20000, 1'b0, -1, d, n);
    chk("div3_data", d, 32'h00000513);
    chk("div3_busy", 32'(n), 32'(EXPB1));
    chk("div3_period", 32'(fl[1].period), 32'd60);
    chk("div3_sck_periods", 32'(fl[1].total_rises - rises0), 32'(NB));
    chk("div3_cmd", fl[1].cmdw, {CMDB, 24'h080000});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
